// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus: ID instruction fields in, per-stage control bits out.
interface pipelined_control_unit_if #(
    parameter int REG_ADDR_W = 5
);
    logic [5:0]            Opcode;
    logic [5:0]            Funct;
    logic [REG_ADDR_W-1:0] Rs;
    logic [REG_ADDR_W-1:0] Rt;
    logic [REG_ADDR_W-1:0] Rd;
    logic                  Flush;

    logic                  PC_Write;
    logic                  IFID_Write;
    logic                  Busy;
    logic                  EX_ALUSrc0;
    logic [1:0]            EX_ALUSrc1;
    logic                  EX_RegDst;
    logic                  MEM_R_Enable;
    logic                  MEM_W_Enable;
    logic [1:0]            MEM_R_Width;
    logic [1:0]            MEM_W_Width;
    logic                  WB_MemToReg;
    logic                  WB_RegWrite;
    logic [REG_ADDR_W-1:0] WB_WriteReg;
    logic                  IllegalOp;

    modport master (
        output Opcode, Funct, Rs, Rt, Rd, Flush,
        input  PC_Write, IFID_Write, Busy, EX_ALUSrc0, EX_ALUSrc1, EX_RegDst,
               MEM_R_Enable, MEM_W_Enable, MEM_R_Width, MEM_W_Width,
               WB_MemToReg, WB_RegWrite, WB_WriteReg, IllegalOp
    );

    modport slave (
        input  Opcode, Funct, Rs, Rt, Rd, Flush,
        output PC_Write, IFID_Write, Busy, EX_ALUSrc0, EX_ALUSrc1, EX_RegDst,
               MEM_R_Enable, MEM_W_Enable, MEM_R_Width, MEM_W_Width,
               WB_MemToReg, WB_RegWrite, WB_WriteReg, IllegalOp
    );
endinterface

// File: rtl/pipelined_control_unit.sv
// MIPS 5-stage control unit: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// pipeline, load-use stall, multi-cycle mul stall and flush bubbles.
module pipelined_control_unit #(
    parameter int MUL_LATENCY = 3,
    parameter int REG_ADDR_W  = 5
) (
    input  logic                     Clk,
    input  logic                     Rst,
    pipelined_control_unit_if.slave  bus
);
    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    // Full control word carried by ID/EX; an all-zero word is a bubble.
    typedef struct packed {
        logic                  alu_src0;
        logic [1:0]            alu_src1;
        logic                  reg_dst;
        logic                  r_en;
        logic                  w_en;
        logic [1:0]            r_width;
        logic [1:0]            w_width;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] write_reg;
    } ex_ctrl_t;

    typedef struct packed {
        logic                  r_en;
        logic                  w_en;
        logic [1:0]            r_width;
        logic [1:0]            w_width;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] write_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic                  mem_to_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] write_reg;
    } wb_ctrl_t;

    ex_ctrl_t   dec;
    ex_ctrl_t   idex;
    mem_ctrl_t  exmem;
    wb_ctrl_t   memwb;
    logic       dec_illegal;
    logic       dec_is_mul;
    logic       dec_is_jal;
    logic       uses_rs;
    logic       uses_rt;
    logic       illegal_q;
    logic [CNT_W-1:0] mul_cnt;

    logic       busy;
    logic       ex_load_hit;
    logic       load_use;
    logic       idex_take;

    // ID decode: control word, register usage and WriteReg resolution.
    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec_is_mul  = 1'b0;
        dec_is_jal  = 1'b0;
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        case (bus.Opcode)
            6'b000000: begin
                uses_rs = 1'b1;
                // jr keeps every control bit at 0
                if (bus.Funct != 6'b001000) begin
                    dec.reg_dst    = 1'b1;
                    dec.alu_src1   = 2'd2;
                    dec.mem_to_reg = 1'b1;
                    dec.reg_write  = 1'b1;
                    uses_rt        = 1'b1;
                    if (bus.Funct == 6'b000000 || bus.Funct == 6'b000010) begin
                        dec.alu_src0 = 1'b1;
                        uses_rs      = 1'b0;
                    end
                end
            end
            6'b011100: begin
                dec.reg_dst    = 1'b1;
                dec.alu_src1   = 2'd2;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec_is_mul     = 1'b1;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            6'b100011, 6'b100001, 6'b100000: begin
                dec.alu_src1  = 2'd1;
                dec.r_en      = 1'b1;
                dec.reg_write = 1'b1;
                dec.r_width   = (bus.Opcode == 6'b100011) ? 2'd0 :
                                (bus.Opcode == 6'b100001) ? 2'd1 : 2'd2;
                uses_rs       = 1'b1;
            end
            6'b101011, 6'b101001, 6'b101000: begin
                dec.alu_src1 = 2'd1;
                dec.w_en     = 1'b1;
                dec.w_width  = (bus.Opcode == 6'b101011) ? 2'd0 :
                               (bus.Opcode == 6'b101001) ? 2'd1 : 2'd2;
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
            end
            6'b001000, 6'b001101, 6'b001110, 6'b001010: begin
                dec.alu_src1   = 2'd1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                uses_rs        = 1'b1;
            end
            6'b000100, 6'b000101: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            6'b000001, 6'b000110, 6'b000111: begin
                uses_rs = 1'b1;
            end
            6'b000010: begin
                // j: no controls, no source registers
            end
            6'b000011: begin
                dec.alu_src1   = 2'd3;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec_is_jal     = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_is_jal)
            dec.write_reg = REG_ADDR_W'(31);
        else if (dec.reg_dst)
            dec.write_reg = bus.Rd;
        else
            dec.write_reg = bus.Rt;

        // writes to $0 are architecturally discarded
        if (dec.write_reg == '0)
            dec.reg_write = 1'b0;
    end

    // Hazard resolution, priority busy > flush > load-use.
    always_comb begin
        busy        = (mul_cnt != '0);
        ex_load_hit = idex.r_en && (idex.write_reg != '0) &&
                      (((idex.write_reg == bus.Rs) && uses_rs) ||
                       ((idex.write_reg == bus.Rt) && uses_rt));
        load_use    = !busy && !bus.Flush && ex_load_hit;
        idex_take   = !busy && !bus.Flush && !load_use;
    end

    // Mul occupancy counter: loads when a mul enters EX, counts down while busy.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            mul_cnt <= '0;
        else if (busy)
            mul_cnt <= mul_cnt - CNT_W'(1);
        else if (idex_take && dec_is_mul)
            mul_cnt <= CNT_W'(MUL_LATENCY - 1);
    end

    // Control pipeline registers; bubbles are all-zero words.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            idex      <= '0;
            exmem     <= '0;
            memwb     <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (!busy)
                idex <= idex_take ? dec : '0;
            exmem     <= busy ? '0 : {idex.r_en, idex.w_en, idex.r_width, idex.w_width,
                                      idex.mem_to_reg, idex.reg_write, idex.write_reg};
            memwb     <= {exmem.mem_to_reg, exmem.reg_write, exmem.write_reg};
            // pulse only when the undecodable instruction actually enters EX
            illegal_q <= idex_take && dec_illegal;
        end
    end

    assign bus.PC_Write     = !(busy || load_use);
    assign bus.IFID_Write   = !(busy || load_use);
    assign bus.Busy         = busy;
    assign bus.EX_ALUSrc0   = idex.alu_src0;
    assign bus.EX_ALUSrc1   = idex.alu_src1;
    assign bus.EX_RegDst    = idex.reg_dst;
    assign bus.MEM_R_Enable = exmem.r_en;
    assign bus.MEM_W_Enable = exmem.w_en;
    assign bus.MEM_R_Width  = exmem.r_width;
    assign bus.MEM_W_Width  = exmem.w_width;
    assign bus.WB_MemToReg  = memwb.mem_to_reg;
    assign bus.WB_RegWrite  = memwb.reg_write;
    assign bus.WB_WriteReg  = memwb.write_reg;
    assign bus.IllegalOp    = illegal_q;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboarded bench: stimulus pushes hand-computed expectations tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_pipelined_control_unit;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    pipelined_control_unit_if #(.REG_ADDR_W(5)) bus  ();
    pipelined_control_unit_if #(.REG_ADDR_W(5)) bus2 ();

    pipelined_control_unit #(.MUL_LATENCY(3), .REG_ADDR_W(5)) u_dut (
        .Clk (Clk), .Rst (Rst), .bus (bus)
    );
    pipelined_control_unit #(.MUL_LATENCY(1), .REG_ADDR_W(5)) u_dut1 (
        .Clk (Clk), .Rst (Rst), .bus (bus2)
    );

    localparam logic [5:0] OP_R = 6'b000000, OP_MUL = 6'b011100, OP_LW = 6'b100011,
                           OP_LH = 6'b100001, OP_SB = 6'b101000, OP_JAL = 6'b000011,
                           OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_MUL = 6'b000010;

    typedef enum int {S_PCW, S_IFID, S_BUSY, S_SRC1, S_MRE, S_MWE, S_MWW,
                      S_MTR, S_RW, S_WR, S_ILL, S_BUSY2, S_RW2, S_WR2} sel_e;
    typedef struct {
        int    cyc;
        sel_e  sel;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int get(input sel_e s);
        int v;
        v = 0;
        case (s)
            S_PCW:   v = int'(bus.PC_Write);
            S_IFID:  v = int'(bus.IFID_Write);
            S_BUSY:  v = int'(bus.Busy);
            S_SRC1:  v = int'(bus.EX_ALUSrc1);
            S_MRE:   v = int'(bus.MEM_R_Enable);
            S_MWE:   v = int'(bus.MEM_W_Enable);
            S_MWW:   v = int'(bus.MEM_W_Width);
            S_MTR:   v = int'(bus.WB_MemToReg);
            S_RW:    v = int'(bus.WB_RegWrite);
            S_WR:    v = int'(bus.WB_WriteReg);
            S_ILL:   v = int'(bus.IllegalOp);
            S_BUSY2: v = int'(bus2.Busy);
            S_RW2:   v = int'(bus2.WB_RegWrite);
            S_WR2:   v = int'(bus2.WB_WriteReg);
            default: v = -1;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input string name, input sel_e s, input int v, input int off);
        exp_t e;
        e.cyc  = cyc + off;
        e.sel  = s;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    // Present one instruction in ID (both DUTs see identical inputs).
    task automatic id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic fl);
        @(posedge Clk);
        #1;
        bus.Opcode  = op; bus.Funct  = fn; bus.Rs  = rs; bus.Rt  = rt; bus.Rd  = rd; bus.Flush  = fl;
        bus2.Opcode = op; bus2.Funct = fn; bus2.Rs = rs; bus2.Rt = rt; bus2.Rd = rd; bus2.Flush = fl;
    endtask

    task automatic nop();
        id(OP_R, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge Clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].name, get(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        bus.Opcode  = '0; bus.Funct  = '0; bus.Rs  = '0; bus.Rt  = '0; bus.Rd  = '0; bus.Flush  = 1'b0;
        bus2.Opcode = '0; bus2.Funct = '0; bus2.Rs = '0; bus2.Rt = '0; bus2.Rd = '0; bus2.Flush = 1'b0;
        #2;
        chk("rst_pcw",  get(S_PCW), 1);
        chk("rst_ifid", get(S_IFID), 1);
        chk("rst_busy", get(S_BUSY), 0);
        chk("rst_rw",   get(S_RW), 0);
        chk("rst_wr",   get(S_WR), 0);
        chk("rst_ill",  get(S_ILL), 0);
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        repeat (2) nop();

        // load-use: lw $t0 ; add $t1,$t0,$t2
        id(OP_LW, 6'd0, 5'd29, 5'd8, 5'd0, 1'b0);
        id(OP_R, FN_ADD, 5'd8, 5'd10, 5'd9, 1'b0);
        expect_at("lu_pcw",      S_PCW,  0, 0);
        expect_at("lu_ifid",     S_IFID, 0, 0);
        expect_at("lu_ex_lw",    S_SRC1, 1, 0);
        expect_at("lu_bubble",   S_SRC1, 0, 1);
        expect_at("lu_mem_lw",   S_MRE,  1, 1);
        expect_at("lu_ex_add",   S_SRC1, 2, 2);
        expect_at("lu_wb_lw_wr", S_WR,   8, 2);
        expect_at("lu_wb_lw_rw", S_RW,   1, 2);
        expect_at("lu_wb_lw_m2r",S_MTR,  0, 2);
        expect_at("lu_wb_bub",   S_RW,   0, 3);
        expect_at("lu_wb_add_rw",S_RW,   1, 4);
        expect_at("lu_wb_add_wr",S_WR,   9, 4);
        id(OP_R, FN_ADD, 5'd8, 5'd10, 5'd9, 1'b0);
        expect_at("lu_release",  S_PCW,  1, 0);
        repeat (4) nop();

        // no hazard: independent sources, and a load to $0
        id(OP_LW, 6'd0, 5'd29, 5'd8, 5'd0, 1'b0);
        id(OP_R, FN_ADD, 5'd11, 5'd11, 5'd9, 1'b0);
        expect_at("nodep_pcw",   S_PCW,  1, 0);
        expect_at("nodep_ex",    S_SRC1, 2, 1);
        id(OP_LW, 6'd0, 5'd29, 5'd0, 5'd0, 1'b0);
        id(OP_R, FN_ADD, 5'd0, 5'd0, 5'd9, 1'b0);
        expect_at("r0_pcw",      S_PCW,  1, 0);
        expect_at("r0_mem",      S_MRE,  1, 1);
        expect_at("r0_wb_rw",    S_RW,   0, 2);
        expect_at("r0_add_rw",   S_RW,   1, 3);
        expect_at("r0_add_wr",   S_WR,   9, 3);
        repeat (4) nop();

        // mul stall (latency 3 vs 1), preceded by a writing add
        id(OP_R, FN_ADD, 5'd1, 5'd2, 5'd9, 1'b0);
        id(OP_MUL, FN_MUL, 5'd17, 5'd18, 5'd16, 1'b0);
        expect_at("mul_add_rw",  S_RW,   1, 2);
        expect_at("mul_add_wr",  S_WR,   9, 2);
        expect_at("mul_ex",      S_SRC1, 2, 1);
        expect_at("mul_busy1",   S_BUSY, 1, 1);
        expect_at("mul_pcw1",    S_PCW,  0, 1);
        expect_at("mul_busy2",   S_BUSY, 1, 2);
        expect_at("mul_ifid2",   S_IFID, 0, 2);
        expect_at("mul_busy3",   S_BUSY, 0, 3);
        expect_at("mul_pcw3",    S_PCW,  1, 3);
        expect_at("mul_bub_a",   S_RW,   0, 3);
        expect_at("mul_bub_b",   S_RW,   0, 4);
        expect_at("mul_wb_rw",   S_RW,   1, 5);
        expect_at("mul_wb_wr",   S_WR,  16, 5);
        expect_at("mul1_busy",   S_BUSY2,0, 1);
        expect_at("mul1_wb_rw",  S_RW2,  1, 3);
        expect_at("mul1_wb_wr",  S_WR2, 16, 3);
        repeat (6) nop();

        // store, flushed load, flush beating load-use
        id(OP_SB, 6'd0, 5'd29, 5'd8, 5'd0, 1'b0);
        expect_at("sb_wen",      S_MWE,  1, 2);
        expect_at("sb_width",    S_MWW,  2, 2);
        expect_at("sb_wb_rw",    S_RW,   0, 3);
        nop();
        id(OP_LH, 6'd0, 5'd29, 5'd9, 5'd0, 1'b1);
        expect_at("fl_pcw",      S_PCW,  1, 0);
        expect_at("fl_ex",       S_SRC1, 0, 1);
        expect_at("fl_mem",      S_MRE,  0, 2);
        expect_at("fl_wb",       S_RW,   0, 3);
        id(OP_LW, 6'd0, 5'd29, 5'd8, 5'd0, 1'b0);
        id(OP_R, FN_ADD, 5'd8, 5'd10, 5'd9, 1'b1);
        expect_at("fl_over_lu",  S_PCW,  1, 0);
        expect_at("fl_over_ex",  S_SRC1, 0, 1);
        repeat (4) nop();

        // illegal opcode and jal
        id(OP_BAD, 6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        expect_at("ill_pulse",   S_ILL,  1, 1);
        expect_at("ill_ex",      S_SRC1, 0, 1);
        expect_at("ill_clear",   S_ILL,  0, 2);
        expect_at("ill_wb",      S_RW,   0, 3);
        nop();
        id(OP_JAL, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_at("jal_src1",    S_SRC1, 3, 1);
        expect_at("jal_wr",      S_WR,  31, 3);
        expect_at("jal_rw",      S_RW,   1, 3);
        expect_at("jal_m2r",     S_MTR,  1, 3);
        repeat (4) nop();

        // async reset in the middle of a mul stall
        id(OP_LW, 6'd0, 5'd29, 5'd8, 5'd0, 1'b0);
        id(OP_MUL, FN_MUL, 5'd17, 5'd18, 5'd16, 1'b0);
        nop();
        expect_at("pre_rst_busy", S_BUSY, 1, 0);
        nop();
        #2 Rst = 1'b1;
        #1;
        chk("arst_busy", get(S_BUSY), 0);
        chk("arst_pcw",  get(S_PCW), 1);
        chk("arst_ifid", get(S_IFID), 1);
        chk("arst_ex",   get(S_SRC1), 0);
        chk("arst_rw",   get(S_RW), 0);
        chk("arst_wr",   get(S_WR), 0);
        @(posedge Clk);
        #1;
        chk("arst_hold_busy", get(S_BUSY), 0);
        Rst = 1'b0;
        nop();
        expect_at("post_rst_busy", S_BUSY, 0, 0);
        expect_at("post_rst_pcw",  S_PCW,  1, 0);
        repeat (6) nop();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
